// File: rtl/overlap_frame_sequencer_if.sv
// Sample-stream bundle between the Hamming window stage and the FFT core:
// windowed input samples in, overlapping frames with start/last markers out.
interface overlap_frame_sequencer_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 7
);
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_re;
    logic [DATA_W-1:0] in_im;
    logic              out_ready;
    logic              out_start;
    logic              out_valid;
    logic [DATA_W-1:0] out_re;
    logic [DATA_W-1:0] out_im;
    logic [ADDR_W-1:0] out_index;
    logic              out_last;
    logic              overflow;
    logic [15:0]       frame_count;

    modport master (
        output flush, in_valid, in_re, in_im, out_ready,
        input  out_start, out_valid, out_re, out_im, out_index, out_last,
               overflow, frame_count
    );

    modport slave (
        input  flush, in_valid, in_re, in_im, out_ready,
        output out_start, out_valid, out_re, out_im, out_index, out_last,
               overflow, frame_count
    );
endinterface

// File: rtl/overlap_frame_sequencer.sv
// Circular sample buffer that replays FRAME_LEN-sample frames advancing by HOP,
// each frame preceded by a one-cycle FFT start pulse.
module overlap_frame_sequencer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 128,
    parameter int ADDR_W    = 7,
    parameter int HOP       = 128
) (
    input logic                     clk,
    input logic                     reset,
    overlap_frame_sequencer_if.slave bus
);
    localparam int DEPTH = 2 * FRAME_LEN;
    localparam int PTR_W = ADDR_W + 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        STREAM = 2'd2
    } state_t;

    state_t              state_r;
    logic [PTR_W-1:0]    wr_ptr_r;
    logic [PTR_W-1:0]    base_r;
    logic [PTR_W-1:0]    rd_ptr_r;
    logic [2*DATA_W-1:0] mem_r [DEPTH];

    logic                out_start_r;
    logic                out_valid_r;
    logic [DATA_W-1:0]   out_re_r;
    logic [DATA_W-1:0]   out_im_r;
    logic [ADDR_W-1:0]   out_index_r;
    logic                out_last_r;
    logic                overflow_r;
    logic [15:0]         frame_count_r;

    logic [PTR_W-1:0]    fill_s;
    logic [PTR_W-1:0]    rd_lead_s;
    logic [PTR_W-1:0]    tail_s;
    logic [PTR_W-1:0]    space_used_s;
    logic                wr_en_s;
    logic                frame_ok_s;
    logic [ADDR_W:0]     rd_addr_s;

    // Occupancy, write acceptance, frame eligibility and read address
    always_comb begin
        fill_s    = wr_ptr_r - base_r;
        rd_lead_s = rd_ptr_r - base_r;
        // Protect the older of the unread rest of this frame and the next frame's start
        if ((state_r == STREAM) && rd_lead_s[PTR_W-1]) begin
            tail_s = rd_ptr_r;
        end else begin
            tail_s = base_r;
        end
        space_used_s = wr_ptr_r - tail_s;
        wr_en_s      = bus.in_valid && (space_used_s < PTR_W'(DEPTH));
        frame_ok_s   = bus.out_ready && (fill_s >= PTR_W'(FRAME_LEN));
        if (state_r == START) begin
            rd_addr_s = base_r[ADDR_W:0];
        end else begin
            rd_addr_s = rd_ptr_r[ADDR_W:0];
        end
    end

    // Sample storage write port
    always_ff @(posedge clk) begin
        if (wr_en_s && !bus.flush) begin
            mem_r[wr_ptr_r[ADDR_W:0]] <= {bus.in_re, bus.in_im};
        end
    end

    // Pointers, frame sequencing and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            wr_ptr_r      <= '0;
            base_r        <= '0;
            rd_ptr_r      <= '0;
            out_start_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_re_r      <= '0;
            out_im_r      <= '0;
            out_index_r   <= '0;
            out_last_r    <= 1'b0;
            overflow_r    <= 1'b0;
            frame_count_r <= 16'd0;
        end else if (bus.flush) begin
            state_r       <= IDLE;
            wr_ptr_r      <= '0;
            base_r        <= '0;
            rd_ptr_r      <= '0;
            out_start_r   <= 1'b0;
            out_valid_r   <= 1'b0;
            out_re_r      <= '0;
            out_im_r      <= '0;
            out_index_r   <= '0;
            out_last_r    <= 1'b0;
            overflow_r    <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            overflow_r  <= bus.in_valid && !wr_en_s;
            out_start_r <= 1'b0;
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            case (state_r)
                IDLE: begin
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    out_index_r <= '0;
                    if (frame_ok_s) begin
                        state_r     <= START;
                        out_start_r <= 1'b1;
                    end
                end
                START: begin
                    {out_re_r, out_im_r} <= mem_r[rd_addr_s];
                    out_valid_r   <= 1'b1;
                    out_index_r   <= '0;
                    out_last_r    <= 1'b0;
                    rd_ptr_r      <= base_r + PTR_W'(1);
                    base_r        <= base_r + PTR_W'(HOP);
                    frame_count_r <= frame_count_r + 16'd1;
                    state_r       <= STREAM;
                end
                STREAM: begin
                    {out_re_r, out_im_r} <= mem_r[rd_addr_s];
                    out_valid_r <= 1'b1;
                    out_index_r <= out_index_r + ADDR_W'(1);
                    rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
                    // out_index_r lags the read by one, so FRAME_LEN-2 marks the final read
                    if (out_index_r == ADDR_W'(FRAME_LEN - 2)) begin
                        out_last_r <= 1'b1;
                        state_r    <= IDLE;
                    end else begin
                        out_last_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                    out_index_r <= '0;
                end
            endcase
        end
    end

    assign bus.out_start   = out_start_r;
    assign bus.out_valid   = out_valid_r;
    assign bus.out_re      = out_re_r;
    assign bus.out_im      = out_im_r;
    assign bus.out_index   = out_index_r;
    assign bus.out_last    = out_last_r;
    assign bus.overflow    = overflow_r;
    assign bus.frame_count = frame_count_r;
endmodule

// File: tb/tb_overlap_frame_sequencer.sv
// Three sequencers (HOP 8, 2, 4; FRAME_LEN 8) share one stimulus stream and are
// checked every cycle against a sample-index model, plus directed literal checks.
module tb_overlap_frame_sequencer;
    localparam int F  = 8;
    localparam int AW = 3;
    localparam int DW = 32;
    localparam int NB = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic [DW-1:0] in_re = '0;
    logic [DW-1:0] in_im = '0;

    always #5 clk = ~clk;

    overlap_frame_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) if0 ();
    overlap_frame_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) if1 ();
    overlap_frame_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) if2 ();

    assign if0.flush = flush; assign if0.in_valid = in_valid; assign if0.in_re = in_re;
    assign if0.in_im = in_im; assign if0.out_ready = out_ready;
    assign if1.flush = flush; assign if1.in_valid = in_valid; assign if1.in_re = in_re;
    assign if1.in_im = in_im; assign if1.out_ready = out_ready;
    assign if2.flush = flush; assign if2.in_valid = in_valid; assign if2.in_re = in_re;
    assign if2.in_im = in_im; assign if2.out_ready = out_ready;

    overlap_frame_sequencer #(.DATA_W(DW), .FRAME_LEN(F), .ADDR_W(AW), .HOP(8))
        dut0 (.clk(clk), .reset(reset), .bus(if0));
    overlap_frame_sequencer #(.DATA_W(DW), .FRAME_LEN(F), .ADDR_W(AW), .HOP(2))
        dut1 (.clk(clk), .reset(reset), .bus(if1));
    overlap_frame_sequencer #(.DATA_W(DW), .FRAME_LEN(F), .ADDR_W(AW), .HOP(4))
        dut2 (.clk(clk), .reset(reset), .bus(if2));

    logic [2:0]    o_start, o_valid, o_last, o_ovf;
    logic [DW-1:0] o_re [3];
    logic [DW-1:0] o_im [3];
    logic [AW-1:0] o_idx [3];
    logic [15:0]   o_fc [3];
    assign o_start = {if2.out_start, if1.out_start, if0.out_start};
    assign o_valid = {if2.out_valid, if1.out_valid, if0.out_valid};
    assign o_last  = {if2.out_last, if1.out_last, if0.out_last};
    assign o_ovf   = {if2.overflow, if1.overflow, if0.overflow};
    assign o_re[0] = if0.out_re; assign o_re[1] = if1.out_re; assign o_re[2] = if2.out_re;
    assign o_im[0] = if0.out_im; assign o_im[1] = if1.out_im; assign o_im[2] = if2.out_im;
    assign o_idx[0] = if0.out_index; assign o_idx[1] = if1.out_index; assign o_idx[2] = if2.out_index;
    assign o_fc[0] = if0.frame_count; assign o_fc[1] = if1.frame_count; assign o_fc[2] = if2.frame_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: accepted samples by index, frames by (start cycle, number)
    int hop [3] = '{8, 2, 4};
    int acc [3];
    int nfr [3];
    int fst [3];
    int cyc = 0;
    logic [DW-1:0] mre [3][NB];
    logic [DW-1:0] mim [3][NB];
    logic e_start [3];
    logic e_valid [3];
    logic e_last [3];
    logic e_ovf [3];
    logic [DW-1:0] e_re [3];
    logic [DW-1:0] e_im [3];
    int e_idx [3];
    int e_fc [3];

    task automatic model_clear(input int d);
        acc[d] = 0; nfr[d] = 0; fst[d] = 0;
        e_start[d] = 1'b0; e_valid[d] = 1'b0; e_last[d] = 1'b0; e_ovf[d] = 1'b0;
        e_re[d] = '0; e_im[d] = '0; e_idx[d] = 0; e_fc[d] = 0;
    endtask

    task automatic model_step(input int d);
        int prev, base, tail, k;
        bit active, elig;
        prev = cyc - 1;
        base = nfr[d] * hop[d];
        active = (nfr[d] > 0) && (prev >= fst[d]) && (prev < fst[d] + F);
        tail = base;
        if (active) begin
            tail = (nfr[d] - 1) * hop[d] + (prev - fst[d]);
            if (base < tail) tail = base;
        end
        elig = !active && out_ready && (acc[d] - base >= F);
        e_ovf[d] = 1'b0;
        if (in_valid) begin
            if ((acc[d] - tail < 2 * F) && (acc[d] < NB)) begin
                mre[d][acc[d]] = in_re;
                mim[d][acc[d]] = in_im;
                acc[d]++;
            end else begin
                e_ovf[d] = 1'b1;
            end
        end
        if (elig) begin
            fst[d] = cyc;
            nfr[d]++;
        end
        e_start[d] = (nfr[d] > 0) && (cyc == fst[d]);
        if ((nfr[d] > 0) && (cyc > fst[d]) && (cyc <= fst[d] + F)) begin
            k = cyc - fst[d] - 1;
            e_valid[d] = 1'b1;
            e_idx[d] = k;
            e_last[d] = (k == F - 1);
            e_re[d] = mre[d][(nfr[d] - 1) * hop[d] + k];
            e_im[d] = mim[d][(nfr[d] - 1) * hop[d] + k];
        end else begin
            e_valid[d] = 1'b0;
            e_idx[d] = 0;
            e_last[d] = 1'b0;
        end
        e_fc[d] = (e_start[d] ? nfr[d] - 1 : nfr[d]) % 65536;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) model_clear(d);
        forever begin
            @(posedge clk or posedge reset);
            if (reset || flush) begin
                for (int d = 0; d < 3; d++) model_clear(d);
            end else begin
                cyc++;
                for (int d = 0; d < 3; d++) model_step(d);
            end
        end
    end

    // Per-cycle output logs used by the directed checks
    logic [DW-1:0] lv [3][256];
    logic lf [3][256];
    int lx [3][256];
    int ln [3];
    int ns [3];
    int no [3];

    task automatic clear_logs();
        for (int d = 0; d < 3; d++) begin
            ln[d] = 0; ns[d] = 0; no[d] = 0;
        end
    endtask

    initial begin
        clear_logs();
        forever begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                tests_run++;
                if (o_start[d] !== e_start[d] || o_valid[d] !== e_valid[d] ||
                    o_last[d] !== e_last[d] || o_ovf[d] !== e_ovf[d] ||
                    o_re[d] !== e_re[d] || o_im[d] !== e_im[d] ||
                    o_idx[d] !== AW'(e_idx[d]) || o_fc[d] !== 16'(e_fc[d])) begin
                    tests_failed++;
                    $display("FAIL cycle_cmp dut%0d t=%0t got st=%b v=%b l=%b ov=%b re=%h im=%h idx=%0d fc=%0d, want st=%b v=%b l=%b ov=%b re=%h im=%h idx=%0d fc=%0d",
                             d, $time, o_start[d], o_valid[d], o_last[d], o_ovf[d], o_re[d], o_im[d],
                             o_idx[d], o_fc[d], e_start[d], e_valid[d], e_last[d], e_ovf[d],
                             e_re[d], e_im[d], e_idx[d], e_fc[d]);
                end
                if (o_valid[d] && ln[d] < 256) begin
                    lv[d][ln[d]] = o_re[d];
                    lf[d][ln[d]] = o_last[d];
                    lx[d][ln[d]] = int'(o_idx[d]);
                    ln[d]++;
                end
                if (o_start[d]) ns[d]++;
                if (o_ovf[d]) no[d]++;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    function automatic int ramp_bad(input int d, input int first, input int n, input int v0);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (first + i >= ln[d] || lv[d][first + i] != DW'(v0 + i)) bad++;
        end
        return bad;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic feed(input int v);
        in_valid = 1'b1;
        in_re = DW'(v);
        in_im = $urandom;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        clear_logs();
    endtask

    initial begin
        int bad, nlast, found, rdy_mode;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Non-overlapping frames of a continuous ramp
        do_flush();
        out_ready = 1'b1;
        for (int v = 0; v < 24; v++) feed(v);
        idle(80);
        chk("t1_frame_count", int'(o_fc[0]), 3);
        chk("t1_starts", ns[0], 3);
        chk("t1_samples", ln[0], 24);
        chk("t1_order", ramp_bad(0, 0, 24, 0), 0);

        // HOP=2 overlap
        do_flush();
        for (int v = 0; v < 16; v++) feed(v);
        idle(80);
        chk("t2_frame_count", int'(o_fc[1]), 5);
        chk("t2_samples", ln[1], 40);
        chk("t2_frame2", ramp_bad(1, 16, 8, 4), 0);
        bad = 0; nlast = 0;
        for (int i = 0; i < ln[1]; i++) begin
            if (lf[1][i]) begin
                if (lv[1][i] != DW'(7 + 2 * nlast)) bad++;
                nlast++;
            end
        end
        chk("t2_last_count", nlast, 5);
        chk("t2_last_values", bad, 0);

        // Backpressure fills the buffer and drops the excess
        do_flush();
        out_ready = 1'b0;
        for (int v = 0; v < 20; v++) feed(v);
        idle(3);
        chk("t3_no_start", ns[0], 0);
        chk("t3_overflows", no[0], 4);
        out_ready = 1'b1;
        idle(40);
        chk("t3_frame_count", int'(o_fc[0]), 2);
        chk("t3_samples", ln[0], 16);
        chk("t3_order", ramp_bad(0, 0, 16, 0), 0);

        // Gapped input, HOP=4
        do_flush();
        for (int v = 0; v < 12; v++) begin
            feed(v);
            idle(2);
        end
        idle(40);
        chk("t4_frame_count", int'(o_fc[2]), 2);
        chk("t4_samples", ln[2], 16);
        chk("t4_frame0", ramp_bad(2, 0, 8, 0), 0);
        chk("t4_frame1", ramp_bad(2, 8, 8, 4), 0);
        chk("t4_overflows", no[2], 0);

        // Asynchronous reset in the middle of a frame
        do_flush();
        for (int v = 0; v < 8; v++) feed(v);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            if (o_valid[0] && o_idx[0] == AW'(3)) found = 1;
            else tick();
        end
        chk("t5_reached_idx3", found, 1);
        reset = 1'b1;
        #1;
        chk("t5_valid_cleared", int'(o_valid[0]), 0);
        chk("t5_re_cleared", int'(o_re[0]), 0);
        chk("t5_fc_cleared", int'(o_fc[0]), 0);
        idle(2);
        reset = 1'b0;
        clear_logs();
        for (int v = 100; v < 108; v++) feed(v);
        idle(20);
        chk("t5_samples", ln[0], 8);
        chk("t5_order", ramp_bad(0, 0, 8, 100), 0);
        bad = 0;
        for (int i = 0; i < ln[0]; i++) begin
            if (lx[0][i] != i || lf[0][i] != (i == 7)) bad++;
        end
        chk("t5_index_last", bad, 0);

        // flush collides with an input sample while partially filled
        do_flush();
        for (int v = 50; v < 56; v++) feed(v);
        in_valid = 1'b1;
        in_re = DW'(999);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        clear_logs();
        for (int v = 200; v < 208; v++) feed(v);
        idle(20);
        chk("t6_frame_count", int'(o_fc[0]), 1);
        chk("t6_samples", ln[0], 8);
        chk("t6_order", ramp_bad(0, 0, 8, 200), 0);

        // Randomized traffic, backpressure and occasional flush
        do_flush();
        rdy_mode = 0;
        for (int i = 0; i < 1200; i++) begin
            if (i % 50 == 0) rdy_mode = int'($urandom_range(0, 2));
            in_valid = ($urandom_range(0, 3) != 0);
            in_re = $urandom;
            in_im = $urandom;
            out_ready = (rdy_mode == 0) ? ($urandom_range(0, 5) == 0) : 1'b1;
            flush = ($urandom_range(0, 299) == 0);
            tick();
        end
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle(80);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
